cart_dump: RTL and testbench

Cartridge bus initiator that reads the complete ROM image back out through the MBC1 mapper and streams it, byte by byte, to a UART byte transmitter. It drives the same address/data/load/store interface the CPU uses toward the mapper. Bank 0 is read through the fixed window. Each higher bank is selected by a bank-register write to 0x2000, then read through the 0x4000–0x7FFF window. It sits beside the CPU on the cartridge bus, and top-level arbitration gives it the bus while `busy` is high. It is used to verify UART-programmed ROM contents.

---
 rtl/cart_dump_pkg.sv | 17 +
 rtl/cart_dump.sv | 144 ++++++++++++++
 tb/tb_cart_dump.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_dump_pkg.sv
// cart_dump shared types and constants.
// FSM state encoding and MBC1 bus addresses.
package cart_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    READ,
    SEND,
    NEXT,
    DONE
  } state_t;

  localparam logic [15:0] BANK_REG_ADDR = 16'h2000;
  localparam logic [15:0] BANK_WINDOW   = 16'h4000;

endpackage

// File: rtl/cart_dump.sv
// Cartridge ROM dumper: walks every MBC1 bank
// and streams each byte to a UART transmitter.
module cart_dump
  import cart_dump_pkg::*;
#(
  parameter int BANKS        = 4,
  parameter int READ_LATENCY = 2,
  // offset width; 14 gives the 16 KiB MBC1 bank
  parameter int OFFSET_W     = 14
) (
  input  logic        clock4,
  input  logic        resetn,
  input  logic        start,
  output logic [15:0] address,
  output logic [7:0]  outdata,
  input  logic [7:0]  indata,
  output logic        load,
  output logic        store,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] checksum
);

  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] LAT_LOAD =
    CW'(READ_LATENCY - 1);
  localparam logic [2:0] END_BANK = 3'(BANKS);
  localparam logic [OFFSET_W-1:0] OFF_MAX = '1;

  state_t              r_state;
  state_t              w_next;
  logic [OFFSET_W-1:0] r_offset;
  logic [2:0]          r_bank;
  logic [CW-1:0]       r_cnt;
  logic [7:0]          r_tx_data;
  logic [15:0]         r_checksum;

  logic                w_wrap;
  logic                w_rd_last;
  logic [2:0]          w_bank_inc;

  assign w_wrap     = (r_offset == OFF_MAX);
  assign w_rd_last  = (r_cnt == '0);
  assign w_bank_inc = r_bank + 3'd1;

  // State register.
  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode; bank wrap picks SELECT or DONE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (start) w_next = READ;
      SELECT: w_next = READ;
      READ:   if (w_rd_last) w_next = SEND;
      SEND:   if (tx_ready) w_next = NEXT;
      NEXT: begin
        if (!w_wrap)
          w_next = READ;
        else if (w_bank_inc == END_BANK)
          w_next = DONE;
        else
          w_next = SELECT;
      end
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Offset, bank, latency counter, byte and checksum.
  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn) begin
      r_offset   <= '0;
      r_bank     <= '0;
      r_cnt      <= '0;
      r_tx_data  <= '0;
      r_checksum <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_offset   <= '0;
            r_bank     <= '0;
            r_cnt      <= LAT_LOAD;
            r_checksum <= '0;
          end
        end
        SELECT: r_cnt <= LAT_LOAD;
        READ: begin
          if (w_rd_last) r_tx_data <= indata;
          else           r_cnt <= r_cnt - CW'(1);
        end
        SEND: begin
          if (tx_ready)
            r_checksum <= r_checksum + {8'h00, r_tx_data};
        end
        NEXT: begin
          r_offset <= r_offset + OFFSET_W'(1);
          r_cnt    <= LAT_LOAD;
          if (w_wrap) r_bank <= w_bank_inc;
        end
        default: ;
      endcase
    end
  end

  // Bus and stream outputs decoded from state.
  always_comb begin
    address  = '0;
    outdata  = '0;
    load     = 1'b0;
    store    = 1'b0;
    tx_valid = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      SELECT: begin
        address = BANK_REG_ADDR;
        outdata = {6'b0, r_bank[1:0]};
        store   = 1'b1;
      end
      READ: begin
        load = 1'b1;
        if (r_bank == 3'd0)
          address = 16'(r_offset);
        else
          address = BANK_WINDOW | 16'(r_offset);
      end
      SEND:    tx_valid = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign busy     = (r_state != IDLE);
  assign tx_data  = r_tx_data;
  assign checksum = r_checksum;

endmodule

// File: tb/tb_cart_dump.sv
// Bench for cart_dump: two instances with small banks
// against a mapper/ROM model and a byte-stream model.
module tb_cart_dump;

  localparam int OW = 4;
  localparam int NB = 1 << OW;
  localparam int A_BANKS = 4;
  localparam int A_RL = 3;
  localparam int B_BANKS = 2;
  localparam int B_RL = 1;
  localparam int BUDGET = 5000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        a_start = 0, a_ld, a_st, a_txv;
  logic        a_rdy = 0, a_busy, a_done;
  logic [15:0] a_addr, a_cs;
  logic [7:0]  a_od, a_in, a_txd;
  logic        b_start = 0, b_ld, b_st, b_txv;
  logic        b_rdy = 0, b_busy, b_done;
  logic [15:0] b_addr, b_cs;
  logic [7:0]  b_od, b_in, b_txd;

  cart_dump #(
    .BANKS(A_BANKS), .READ_LATENCY(A_RL),
    .OFFSET_W(OW)
  ) u_a (
    .clock4(clk), .resetn(rstn), .start(a_start),
    .address(a_addr), .outdata(a_od), .indata(a_in),
    .load(a_ld), .store(a_st), .tx_data(a_txd),
    .tx_valid(a_txv), .tx_ready(a_rdy),
    .busy(a_busy), .done(a_done), .checksum(a_cs)
  );

  cart_dump #(
    .BANKS(B_BANKS), .READ_LATENCY(B_RL),
    .OFFSET_W(OW)
  ) u_b (
    .clock4(clk), .resetn(rstn), .start(b_start),
    .address(b_addr), .outdata(b_od), .indata(b_in),
    .load(b_ld), .store(b_st), .tx_data(b_txd),
    .tx_valid(b_txv), .tx_ready(b_rdy),
    .busy(b_busy), .done(b_done), .checksum(b_cs)
  );

  logic [7:0] rom [4][NB];
  logic [1:0] a_sel = 2'd1;
  logic [1:0] b_sel = 2'd1;
  int         a_run = 0;
  int         b_run = 0;
  logic       cpu_wr_a = 0, cpu_wr_b = 0;
  logic [1:0] cpu_val = 0;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] rom_rd(
    input logic [1:0] sel, input logic [15:0] adr);
    if (adr[13:OW] != '0) return 8'hEE;
    if (adr[15:14] == 2'b00) return rom[0][adr[OW-1:0]];
    if (adr[15:14] == 2'b01) return rom[sel][adr[OW-1:0]];
    return 8'hEE;
  endfunction

  // MBC1 model: bank register and read latency.
  always @(posedge clk) begin
    if (cpu_wr_a) a_sel <= cpu_val;
    else if (a_st && a_addr == 16'h2000)
      a_sel <= (a_od[1:0] == 2'd0) ? 2'd1 : a_od[1:0];
    a_run <= a_ld ? a_run + 1 : 0;
    if (cpu_wr_b) b_sel <= cpu_val;
    else if (b_st && b_addr == 16'h2000)
      b_sel <= (b_od[1:0] == 2'd0) ? 2'd1 : b_od[1:0];
    b_run <= b_ld ? b_run + 1 : 0;
  end

  assign a_in = (a_ld && a_run == A_RL - 1) ?
    rom_rd(a_sel, a_addr) : 8'hEE;
  assign b_in = (b_ld && b_run == B_RL - 1) ?
    rom_rd(b_sel, b_addr) : 8'hEE;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  od;
    logic        ld;
    logic        st;
    logic [7:0]  txd;
    logic        txv;
    logic        busy;
    logic        done;
    logic [15:0] cs;
  } obs_t;

  typedef struct {
    int w;
    int cpu_bank;
    int rdy_mode;
    int spam;
    int rst_at;
    int exp_bytes;
    int exp_stores;
  } vec_t;

  function automatic obs_t view(input int w);
    obs_t o;
    if (w == 0) begin
      o.addr = a_addr; o.od = a_od; o.ld = a_ld;
      o.st = a_st; o.txd = a_txd; o.txv = a_txv;
      o.busy = a_busy; o.done = a_done; o.cs = a_cs;
    end else begin
      o.addr = b_addr; o.od = b_od; o.ld = b_ld;
      o.st = b_st; o.txd = b_txd; o.txv = b_txv;
      o.busy = b_busy; o.done = b_done; o.cs = b_cs;
    end
    return o;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 0) a_start = v;
    else        b_start = v;
  endtask

  task automatic set_rdy(input int w, input logic v);
    if (w == 0) a_rdy = v;
    else        b_rdy = v;
  endtask

  task automatic chk_zero(input int w);
    obs_t o;
    o = view(w);
    chk("rst_addr", o.addr, 0);
    chk("rst_ctrl",
        {o.od, o.txd, o.ld, o.st, o.txv, o.busy, o.done}, 0);
    chk("rst_cs", o.cs, 0);
  endtask

  task automatic run(input vec_t v);
    obs_t o;
    logic [7:0] exp_q[$];
    int stores[$];
    logic [15:0] sum = 0;
    logic [15:0] prev_addr = 0;
    logic [7:0] prev_txd = 0;
    logic [7:0] e;
    bit hold = 0, fin = 0, did_rst = 0, r;
    int banks, rl, got = 0, cyc = 0, busy_cyc = 0;
    int ld_run = 0, dones = 0, after = 0, win = 0;
    banks = (v.w == 0) ? A_BANKS : B_BANKS;
    rl    = (v.w == 0) ? A_RL : B_RL;
    for (int b = 0; b < banks; b++)
      for (int i = 0; i < NB; i++)
        exp_q.push_back(rom[b][i]);
    if (v.cpu_bank > 0) begin
      @(negedge clk);
      cpu_val = 2'(v.cpu_bank);
      if (v.w == 0) cpu_wr_a = 1; else cpu_wr_b = 1;
      @(negedge clk);
      cpu_wr_a = 0; cpu_wr_b = 0;
    end
    @(negedge clk);
    o = view(v.w);
    chk("pre_idle", {o.busy, o.ld, o.st}, 0);
    set_start(v.w, 1);
    @(negedge clk);
    set_start(v.w, 0);
    o = view(v.w);
    chk("start_busy_load", {o.busy, o.ld, o.addr},
        32'h30000);
    while (cyc < BUDGET) begin
      o = view(v.w);
      if (fin) begin
        chk("idle_after_done", {o.busy, o.ld, o.done}, 0);
        set_start(v.w, 0);
        after++;
        if (after == 3) break;
        @(negedge clk); cyc++;
        continue;
      end
      if (v.rst_at >= 0 && got >= v.rst_at) begin
        set_rdy(v.w, 0);
        rstn = 0;
        #1;
        chk_zero(v.w);
        @(negedge clk);
        rstn = 1;
        did_rst = 1;
        break;
      end
      if (o.busy) busy_cyc++;
      case (v.rdy_mode)
        0:       r = 1;
        1:       r = (cyc % 4 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      set_rdy(v.w, r);
      chk("ld_st_excl", {o.ld, o.st} == 2'b11, 0);
      if (o.ld && ld_run == 0 && o.addr == 16'h4000) begin
        win++;
        chk("sel_before_win",
            (stores.size() == win) ? stores[$] : 99, win);
      end
      if (o.ld) begin
        if (ld_run > 0) chk("addr_stable", o.addr, prev_addr);
        ld_run++;
        prev_addr = o.addr;
      end else if (ld_run > 0) begin
        chk("load_len", ld_run, rl);
        ld_run = 0;
      end
      if (o.st) begin
        chk("store_addr", o.addr, 16'h2000);
        stores.push_back(int'(o.od));
      end
      if (o.txv && hold) chk("txd_stable", o.txd, prev_txd);
      hold = o.txv && !r;
      prev_txd = o.txd;
      if (o.txv && r) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_byte: got %0h at count %0d",
                   o.txd, got);
        end else begin
          e = exp_q.pop_front();
          chk("byte", o.txd, e);
        end
        sum += {8'h00, o.txd};
        got++;
      end
      set_start(v.w, 0);
      if (v.spam != 0 && o.busy && cyc % 7 == 3)
        set_start(v.w, 1);
      if (o.done) begin
        dones++;
        chk("checksum", o.cs, sum);
        chk("byte_count", got, v.exp_bytes);
        fin = 1;
        if (v.spam != 0) set_start(v.w, 1);
      end
      @(negedge clk); cyc++;
    end
    set_rdy(v.w, 0);
    set_start(v.w, 0);
    chk("store_count", stores.size(), v.exp_stores);
    for (int k = 0; k < stores.size(); k++)
      chk("store_data", stores[k], k + 1);
    if (did_rst) begin
      chk("rst_byte_count", got, v.exp_bytes);
    end else if (!fin) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d bytes, expected %0d",
               got, v.exp_bytes);
    end else begin
      chk("done_once", dones, 1);
      chk("all_bytes_sent", exp_q.size(), 0);
      if (v.rdy_mode == 0)
        chk("busy_cycles", busy_cyc,
            banks * NB * (rl + 2) + banks);
    end
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{0, 3, 0, 0, -1, A_BANKS * NB, A_BANKS - 1};
    tbl[1] = '{1, 0, 0, 0, -1, B_BANKS * NB, B_BANKS - 1};
    tbl[2] = '{0, 2, 1, 0, -1, A_BANKS * NB, A_BANKS - 1};
    tbl[3] = '{0, 0, 2, 0, 40, 40, 2};
    tbl[4] = '{0, 0, 0, 1, -1, A_BANKS * NB, A_BANKS - 1};
    tbl[5] = '{1, 3, 2, 1, -1, B_BANKS * NB, B_BANKS - 1};
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < NB; i++)
        rom[b][i] = {2'(b), 6'($urandom)};
    repeat (3) @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    rstn = 1;
    for (int t = 0; t < 6; t++) run(tbl[t]);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
